// File: rtl/fir_pkg.sv
// Shared types and constants for the 29-tap symmetric complex FIR control path.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } firc_state_t;

    localparam int FIR_TAPS      = 29;
    localparam int FIR_NCOEF     = 15;
    localparam int FIR_COEF_AMIN = 1;
    localparam int FIR_COEF_AMAX = 15;

    // True when addr names one of the unique coefficients.
    function automatic logic coef_addr_legal(input logic [4:0] addr);
        return (addr >= 5'(FIR_COEF_AMIN)) && (addr <= 5'(FIR_COEF_AMAX));
    endfunction

endpackage

// File: rtl/firc_credit.sv
// Credit counter tracking occupied entries of the downstream output buffer.
// An increment is only honoured while not full, a decrement only while
// non-empty; both together leave the count unchanged.
module firc_credit #(
    parameter int OBUF_DEPTH = 8,
    parameter int CW         = $clog2(OBUF_DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full
);

    logic [CW-1:0] count_r;
    logic          inc_ok_s;
    logic          dec_ok_s;

    assign full     = (count_r == CW'(OBUF_DEPTH));
    assign inc_ok_s = inc && !full;
    assign dec_ok_s = dec && (count_r != {CW{1'b0}});

    // Count register: saturating up/down with simultaneous inc/dec cancelling.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (inc_ok_s && !dec_ok_s) begin
            count_r <= count_r + CW'(1);
        end else if (!inc_ok_s && dec_ok_s) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/firc_ctrl.sv
// Control and sequencing for the 29-tap symmetric complex FIR: coefficient
// load tracking, credit-gated sample acceptance, shift enable and a
// latency-matched PushOut for the MAC pipeline.
// Optional build macro FIRC_WARMUP_EN: the first TAPS-1 accepted samples
// after each RUN entry shift the delay line but are neither credited nor
// reported through PushOut.
module firc_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS       = FIR_TAPS,
    parameter int MAC_LAT    = 4,
    parameter int OBUF_DEPTH = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PushIn,
    output logic       StopIn,
    input  logic       PushCoef,
    input  logic [4:0] CoefAddr,
    input  logic       Flush,
    input  logic       OutPop,
    output logic       coef_we,
    output logic [4:0] coef_waddr,
    output logic       shift_en,
    output logic       PushOut,
    output logic       Ready,
    output logic       CoefErr
);

    localparam int NCOEF = (TAPS + 1) / 2;

    firc_state_t        state_r;
    firc_state_t        state_next_s;
    logic [NCOEF-1:0]   loaded_r;
    logic [NCOEF-1:0]   addr_hot_s;
    logic               coef_err_r;
    logic [MAC_LAT-1:0] lat_line_r;
    logic [MAC_LAT:0]   lat_ext_s;

    logic               addr_ok_s;
    logic               all_loaded_s;
    logic               line_empty_s;
    logic               credit_full_s;
    logic               stop_s;
    logic               accept_s;
    logic               credited_s;
    logic               we_s;
    logic [4:0]         waddr_s;
    logic               err_set_s;
    logic               enter_load_s;
    logic               clr_load_s;

    assign addr_ok_s    = coef_addr_legal(CoefAddr);
    assign all_loaded_s = &loaded_r;
    assign line_empty_s = (lat_line_r == {MAC_LAT{1'b0}});

    // One-hot view of the write address over the coefficient bitmap.
    always_comb begin
        addr_hot_s = {NCOEF{1'b0}};
        for (int i = 0; i < NCOEF; i++) begin
            addr_hot_s[i] = (CoefAddr == 5'(i + 1));
        end
    end

    // Next-state and per-cycle strobes; writes and accepts act in the same cycle.
    always_comb begin
        state_next_s = state_r;
        stop_s       = 1'b1;
        accept_s     = 1'b0;
        we_s         = 1'b0;
        waddr_s      = 5'd0;
        err_set_s    = 1'b0;
        enter_load_s = 1'b0;
        clr_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (PushCoef) begin
                    state_next_s = LOAD;
                    enter_load_s = 1'b1;
                    if (addr_ok_s) begin
                        we_s    = 1'b1;
                        waddr_s = CoefAddr;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (PushCoef) begin
                    if (addr_ok_s) begin
                        we_s    = 1'b1;
                        waddr_s = CoefAddr;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end else if (all_loaded_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = LOAD;
                end
            end
            RUN: begin
                // Flush closes the input at once so nothing new enters the drain.
                stop_s    = credit_full_s || Flush;
                accept_s  = PushIn && !stop_s;
                err_set_s = PushCoef;
                if (Flush) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                err_set_s = PushCoef;
                if (line_empty_s) begin
                    state_next_s = LOAD;
                    enter_load_s = 1'b1;
                    clr_load_s   = 1'b1;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Loaded-coefficient bitmap; cleared when a drain returns to LOAD.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            loaded_r <= {NCOEF{1'b0}};
        end else if (clr_load_s) begin
            loaded_r <= {NCOEF{1'b0}};
        end else if (we_s) begin
            loaded_r <= loaded_r | addr_hot_s;
        end else begin
            loaded_r <= loaded_r;
        end
    end

    // Sticky coefficient-access error; only a drain completion clears it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            coef_err_r <= 1'b0;
        end else if (clr_load_s) begin
            coef_err_r <= 1'b0;
        end else if (err_set_s) begin
            coef_err_r <= 1'b1;
        end else begin
            coef_err_r <= coef_err_r;
        end
    end

`ifdef FIRC_WARMUP_EN
    logic [4:0] warm_cnt_r;
    logic       warm_done_s;

    assign warm_done_s = (warm_cnt_r == 5'(TAPS - 1));
    assign credited_s  = accept_s && warm_done_s;

    // Warm-up counter: counts uncredited accepts until the delay line is full.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            warm_cnt_r <= 5'd0;
        end else if (enter_load_s) begin
            warm_cnt_r <= 5'd0;
        end else if (accept_s && !warm_done_s) begin
            warm_cnt_r <= warm_cnt_r + 5'd1;
        end else begin
            warm_cnt_r <= warm_cnt_r;
        end
    end
`else
    assign credited_s = accept_s;
`endif

    assign lat_ext_s = {lat_line_r, credited_s};

    // Latency line: a credited accept in cycle t reaches the last stage in t+MAC_LAT.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_line_r <= {MAC_LAT{1'b0}};
        end else begin
            lat_line_r <= lat_ext_s[MAC_LAT-1:0];
        end
    end

    firc_credit #(
        .OBUF_DEPTH (OBUF_DEPTH)
    ) u_credit (
        .clk   (Clk),
        .reset (Reset),
        .inc   (credited_s),
        .dec   (OutPop),
        .full  (credit_full_s)
    );

    assign StopIn     = stop_s;
    assign shift_en   = accept_s;
    assign coef_we    = we_s;
    assign coef_waddr = waddr_s;
    assign PushOut    = lat_line_r[MAC_LAT-1];
    assign Ready      = (state_r == RUN);
    assign CoefErr    = coef_err_r;

endmodule

// File: tb/tb_firc_ctrl.sv
// Self-checking bench for firc_ctrl with a cycle-level reference model.
module tb_firc_ctrl;

    localparam int MAC_LAT    = 4;
    localparam int OBUF_DEPTH = 8;
    localparam int WARM       = 28;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       PushIn = 1'b0;
    logic       PushCoef = 1'b0;
    logic [4:0] CoefAddr = 5'd0;
    logic       Flush = 1'b0;
    logic       OutPop = 1'b0;
    logic       StopIn, coef_we, shift_en, PushOut, Ready, CoefErr;
    logic [4:0] coef_waddr;

    firc_ctrl #(.TAPS(29), .MAC_LAT(MAC_LAT), .OBUF_DEPTH(OBUF_DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .PushIn(PushIn), .StopIn(StopIn),
        .PushCoef(PushCoef), .CoefAddr(CoefAddr), .Flush(Flush),
        .OutPop(OutPop), .coef_we(coef_we), .coef_waddr(coef_waddr),
        .shift_en(shift_en), .PushOut(PushOut), .Ready(Ready),
        .CoefErr(CoefErr)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    // Reference model: phase 0=idle 1=load 2=run 3=drain
    int m_st;
    bit m_bits [1:15];
    bit m_err;
    int m_cnt;
    int m_warm;
    int m_due [$];

    logic o_stop, o_we, o_shift, o_po, o_ready, o_err;
    logic [4:0] o_waddr;

    function automatic bit model_all_loaded();
        for (int i = 1; i <= 15; i++) if (!m_bits[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_st = 0; m_err = 1'b0; m_cnt = 0; m_warm = 0;
        for (int i = 1; i <= 15; i++) m_bits[i] = 1'b0;
        m_due.delete();
    endtask

    // One clock cycle: drive, compare all outputs with the model, advance.
    task automatic cyc(input logic push, input logic pc, input logic [4:0] addr,
                       input logic fl, input logic pop);
        logic [10:0] got, want;
        logic e_stop, e_we, e_po;
        logic [4:0] e_waddr;
        bit legal, acc, cred, full_before, drain_empty;
        PushIn = push; PushCoef = pc; CoefAddr = addr; Flush = fl; OutPop = pop;
        #2;
        o_stop = StopIn; o_we = coef_we; o_waddr = coef_waddr; o_shift = shift_en;
        o_po = PushOut; o_ready = Ready; o_err = CoefErr;
        legal = (addr >= 5'd1) && (addr <= 5'd15);
        full_before = model_all_loaded();
        drain_empty = (m_due.size() == 0);
        e_stop = (m_st == 2) ? ((m_cnt == OBUF_DEPTH) || fl) : 1'b1;
        acc = (m_st == 2) && push && !e_stop;
        e_we = pc && legal && (m_st <= 1);
        e_waddr = e_we ? addr : 5'd0;
        e_po = (m_due.size() > 0) && (m_due[0] == cyc_no);
        got  = {o_stop, o_we, o_waddr, o_shift, o_po, o_ready, o_err};
        want = {e_stop, e_we, e_waddr, acc, e_po, (m_st == 2), m_err};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL outputs cyc=%0d stop/we/waddr/shift/po/ready/err got=%b want=%b",
                     cyc_no, got, want);
        end
        cred = acc;
`ifdef FIRC_WARMUP_EN
        if (acc && m_warm < WARM) begin
            cred = 1'b0;
            m_warm++;
        end
`endif
        if (e_po) void'(m_due.pop_front());
        if (cred) m_due.push_back(cyc_no + MAC_LAT);
        if (cred && !(pop && m_cnt > 0)) m_cnt++;
        else if (!cred && pop && m_cnt > 0) m_cnt--;
        if (pc && (!legal || m_st >= 2)) m_err = 1'b1;
        if (e_we) m_bits[addr] = 1'b1;
        case (m_st)
            0: if (pc) begin m_st = 1; m_warm = 0; end
            1: if (!pc && full_before) m_st = 2;
            2: if (fl) m_st = 3;
            default: if (drain_empty) begin
                m_st = 1; m_err = 1'b0; m_warm = 0;
                for (int i = 1; i <= 15; i++) m_bits[i] = 1'b0;
            end
        endcase
        @(posedge Clk); #1;
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic load_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) cyc(1'b0, 1'b1, 5'(a), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [10:0] got;
        Reset = 1'b1; PushIn = 1'b0; PushCoef = 1'b0; CoefAddr = 5'd0;
        Flush = 1'b0; OutPop = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        got = {StopIn, coef_we, coef_waddr, shift_en, PushOut, Ready, CoefErr};
        total++;
        if (got !== 11'b1_0_00000_0_0_0_0) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", got, 11'b10000000000);
        end
        Reset = 1'b0;
        model_clear();
        cyc_no++;
    endtask

    task automatic test_load();
        int we_cnt = 0;
        test_reset();
        for (int a = 1; a <= 15; a++) begin
            cyc(1'b0, 1'b1, 5'(a), 1'b0, 1'b0);
            we_cnt += int'(o_we);
        end
        total++;
        if (we_cnt != 15) begin bad++; $display("FAIL load_we_count got=%0d want=15", we_cnt); end
        idle(1);
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%b want=0", o_ready); end
        idle(1);
        total++;
        if (o_ready !== 1'b1 || o_err !== 1'b0) begin
            bad++; $display("FAIL ready_rise got ready=%b err=%b want 1 0", o_ready, o_err);
        end
    endtask

    task automatic test_illegal();
        test_reset();
        cyc(1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (o_we !== 1'b0) begin bad++; $display("FAIL illegal_addr0_we got=%b want=0", o_we); end
        cyc(1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
        total++;
        if (o_we !== 1'b0) begin bad++; $display("FAIL illegal_addr16_we got=%b want=0", o_we); end
        load_range(1, 14);
        idle(3);
        total++;
        if (o_ready !== 1'b0 || o_err !== 1'b1) begin
            bad++; $display("FAIL illegal_hold got ready=%b err=%b want 0 1", o_ready, o_err);
        end
        load_range(15, 15);
        idle(2);
        total++;
        if (o_ready !== 1'b1 || o_err !== 1'b1) begin
            bad++; $display("FAIL illegal_sticky got ready=%b err=%b want 1 1", o_ready, o_err);
        end
    endtask

    task automatic enter_run();
        test_reset();
        load_range(1, 15);
        idle(2);
    endtask

    task automatic test_fill();
        int acc = 0, po = 0, first_acc = -1, first_po = -1;
        enter_run();
        for (int i = 0; i < 18; i++) begin
            cyc(i < 12, 1'b0, 5'd0, 1'b0, 1'b0);
            if (o_shift && first_acc < 0) first_acc = cyc_no - 1;
            if (o_po && first_po < 0) first_po = cyc_no - 1;
            acc += int'(o_shift);
            po  += int'(o_po);
            if (i == 8) begin
                total++;
                if (o_stop !== 1'b1) begin bad++; $display("FAIL fill_stop9 got=%b want=1", o_stop); end
            end
        end
        total++;
        if (acc != 8 || po != 8) begin
            bad++; $display("FAIL fill_counts got acc=%0d po=%0d want 8 8", acc, po);
        end
        total++;
        if (first_po - first_acc != MAC_LAT) begin
            bad++; $display("FAIL fill_latency got=%0d want=%0d", first_po - first_acc, MAC_LAT);
        end
    endtask

    task automatic test_outpop();
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (o_stop !== 1'b1) begin bad++; $display("FAIL pop_full_stop got=%b want=1", o_stop); end
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (o_stop !== 1'b0 || o_shift !== 1'b1) begin
            bad++; $display("FAIL pop_accept got stop=%b shift=%b want 0 1", o_stop, o_shift);
        end
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (o_stop !== 1'b1) begin bad++; $display("FAIL pop_refull got=%b want=1", o_stop); end
    endtask

    task automatic test_flush();
        int po = 0;
        int guard = 0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        total++;
        if (o_stop !== 1'b1 || o_shift !== 1'b0) begin
            bad++; $display("FAIL flush_stop got stop=%b shift=%b want 1 0", o_stop, o_shift);
        end
        while (m_st != 1 && guard < 30) begin
            cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
            po += int'(o_po);
            guard++;
        end
        total++;
        if (po != 3 || guard >= 30) begin
            bad++; $display("FAIL flush_drain got po=%0d cycles=%0d want po=3", po, guard);
        end
        idle(1);
        total++;
        if (o_err !== 1'b0 || o_ready !== 1'b0) begin
            bad++; $display("FAIL flush_load got err=%b ready=%b want 0 0", o_err, o_ready);
        end
        load_range(1, 14);
        idle(3);
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL flush_bitmap got=%b want=0", o_ready); end
        load_range(15, 15);
        idle(2);
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_reload got=%b want=1", o_ready); end
    endtask

    task automatic test_warmup();
        int sh = 0, po = 0;
        enter_run();
        for (int i = 0; i < 38; i++) begin
            cyc(i < 30, 1'b0, 5'd0, 1'b0, 1'b0);
            sh += int'(o_shift);
            po += int'(o_po);
        end
        total++;
        if (sh != 30 || po != 2) begin
            bad++; $display("FAIL warmup got shift=%0d po=%0d want 30 2", sh, po);
        end
    endtask

    task automatic test_random();
        int po = 0;
        enter_run();
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                5'($urandom_range(0, 31)), 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        for (int i = 0; i < 2 * MAC_LAT; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            po += int'(o_po);
        end
        total++;
        if (po != 0) begin bad++; $display("FAIL reset_discard got po=%0d want=0", po); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_illegal();
`ifdef FIRC_WARMUP_EN
        test_warmup();
`else
        test_fill();
        test_outpop();
        test_flush();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
